// File: rtl/odelay_load_pkg.sv
// Shared definitions for the odelay load sequencer: delay bus width, FSM states and
// a helper that sizes the guard/hold counter.
package odelay_load_pkg;

  localparam int unsigned DELAY_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SET   = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Width able to hold max(a, b); never less than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = 1;
    while ((32'd1 << w) <= m) w++;
    return w;
  endfunction

endpackage

// File: rtl/odelay_shadow_regs.sv
// Shadow copy of every lane's tap value: one write port, one registered read port,
// synchronous reset to DELAY_INIT.
module odelay_shadow_regs
  import odelay_load_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 10,
  parameter int unsigned LANE_W     = 4,
  parameter int unsigned DELAY_INIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [LANE_W-1:0]  wr_lane,
  input  logic [DELAY_W-1:0] wr_data,
  input  logic [LANE_W-1:0]  rd_lane,
  output logic [DELAY_W-1:0] rd_data
);

  logic [DELAY_W-1:0] mem_q [NUM_LANES];
  logic [DELAY_W-1:0] mem_d [NUM_LANES];
  logic [DELAY_W-1:0] rd_q, rd_d;

  // Reads see the table before this cycle's write; out-of-range reads return DELAY_INIT.
  always_comb begin
    mem_d = mem_q;
    rd_d  = DELAY_W'(DELAY_INIT);
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (wr_en && (wr_lane == LANE_W'(i))) mem_d[i] = wr_data;
      if (rd_lane == LANE_W'(i)) rd_d = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) mem_q[i] <= DELAY_W'(DELAY_INIT);
      rd_q <= DELAY_W'(DELAY_INIT);
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/odelay_load_seq.sv
// Sequencer for a bank of odelay_pipe lanes: per-lane ld pulses on load commands and a
// guarded, common set pulse on apply, with a shadow table for readback.
module odelay_load_seq
  import odelay_load_pkg::*;
#(
  parameter int unsigned NUM_LANES    = 10,
  parameter int unsigned LANE_W       = 4,
  parameter int unsigned DELAY_INIT   = 0,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_apply,
  input  logic [LANE_W-1:0]    cmd_lane,
  input  logic [DELAY_W-1:0]   cmd_delay,
  output logic [DELAY_W-1:0]   dly_out,
  output logic [NUM_LANES-1:0] ld_out,
  output logic                 set_out,
  output logic [NUM_LANES-1:0] pending,
  output logic                 done,
  output logic                 err,
  input  logic [LANE_W-1:0]    rd_lane,
  output logic [DELAY_W-1:0]   rd_delay
);

  localparam int unsigned CNT_W = cnt_width(GUARD_CYCLES, HOLD_CYCLES);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DELAY_W-1:0]   dly_q, dly_d;
  logic [NUM_LANES-1:0] ld_q, ld_d;
  logic [NUM_LANES-1:0] pending_q, pending_d;
  logic                 set_q, set_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic accept;
  logic lane_ok;
  logic load_ok;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign lane_ok   = (32'(cmd_lane) < NUM_LANES);
  assign load_ok   = accept && !cmd_apply && lane_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    ld_d      = '0;
    pending_d = pending_q;
    set_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_apply) begin
            state_d = ST_GUARD;
            cnt_d   = CNT_W'(GUARD_CYCLES - 1);
          end else if (lane_ok) begin
            dly_d = cmd_delay;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
              if (cmd_lane == LANE_W'(i)) begin
                ld_d[i]      = 1'b1;
                pending_d[i] = 1'b1;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) begin
          state_d   = ST_SET;
          set_d     = 1'b1;
          pending_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SET: begin
        if (HOLD_CYCLES == 0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dly_q     <= '0;
      ld_q      <= '0;
      pending_q <= '0;
      set_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      ld_q      <= ld_d;
      pending_q <= pending_d;
      set_q     <= set_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  odelay_shadow_regs #(
    .NUM_LANES  (NUM_LANES),
    .LANE_W     (LANE_W),
    .DELAY_INIT (DELAY_INIT)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (load_ok),
    .wr_lane (cmd_lane),
    .wr_data (cmd_delay),
    .rd_lane (rd_lane),
    .rd_data (rd_delay)
  );

  assign dly_out = dly_q;
  assign ld_out  = ld_q;
  assign set_out = set_q;
  assign pending = pending_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_odelay_load_seq.sv
// Bench for odelay_load_seq: directed scenarios then random commands, checked against a
// timeline model that schedules expected pulses by cycle number.
module tb_odelay_load_seq;

  localparam int NL   = 10;
  localparam int LW   = 4;
  localparam int DI   = 6;
  localparam int G    = 2;
  localparam int H    = 4;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_apply;
  logic [LW-1:0] cmd_lane;
  logic [4:0]    cmd_delay;
  logic [4:0]    dly_out;
  logic [NL-1:0] ld_out;
  logic          set_out;
  logic [NL-1:0] pending;
  logic          done;
  logic          err;
  logic [LW-1:0] rd_lane;
  logic [4:0]    rd_delay;

  always #5 clk = ~clk;

  odelay_load_seq #(
    .NUM_LANES    (NL),
    .LANE_W       (LW),
    .DELAY_INIT   (DI),
    .GUARD_CYCLES (G),
    .HOLD_CYCLES  (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_apply (cmd_apply),
    .cmd_lane  (cmd_lane),
    .cmd_delay (cmd_delay),
    .dly_out   (dly_out),
    .ld_out    (ld_out),
    .set_out   (set_out),
    .pending   (pending),
    .done      (done),
    .err       (err),
    .rd_lane   (rd_lane),
    .rd_delay  (rd_delay)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [NL-1:0] exp_ld   [MAXC];
  bit            exp_set  [MAXC];
  bit            exp_done [MAXC];
  bit            exp_err  [MAXC];
  int            shadow_m [NL];
  logic [NL-1:0] pend_m;
  int            dly_m;
  int            exp_rd;
  int            busy_until;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs for this cycle, then advance the model.
  task automatic step(input bit r, input bit v, input bit a, input int l, input int d, input int rl);
    bit rdy;
    bit acc;
    int nxt_rd;
    @(posedge clk);
    #1;
    rst       = r;
    cmd_valid = v;
    cmd_apply = a;
    cmd_lane  = LW'(l);
    cmd_delay = 5'(d);
    rd_lane   = LW'(rl);
    if (exp_set[cyc]) pend_m = '0;
    rdy = !r && (cyc >= busy_until);
    acc = v && rdy;
    @(negedge clk);
    if (cyc > 0) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(rdy));
      chk("ld_out",    32'(ld_out),    32'(exp_ld[cyc]));
      chk("set_out",   32'(set_out),   32'(exp_set[cyc]));
      chk("done",      32'(done),      32'(exp_done[cyc]));
      chk("err",       32'(err),       32'(exp_err[cyc]));
      chk("pending",   32'(pending),   32'(pend_m));
      chk("dly_out",   32'(dly_out),   32'(dly_m));
      chk("rd_delay",  32'(rd_delay),  32'(exp_rd));
      chk("ld_set_excl", 32'((|ld_out) && set_out), 32'(0));
    end
    nxt_rd = shadow_m[rl];
    if (r) begin
      for (int i = 0; i < NL; i++) shadow_m[i] = DI;
      for (int k = cyc + 1; k < cyc + 20; k++) begin
        exp_ld[k]   = '0;
        exp_set[k]  = 1'b0;
        exp_done[k] = 1'b0;
        exp_err[k]  = 1'b0;
      end
      pend_m     = '0;
      dly_m      = 0;
      nxt_rd     = DI;
      busy_until = cyc + 1;
    end else if (acc) begin
      if (a) begin
        busy_until             = cyc + 2 + G + H;
        exp_set[cyc + 1 + G]   = 1'b1;
        exp_done[cyc + 2 + G + H] = 1'b1;
      end else if (l < NL) begin
        exp_ld[cyc + 1] = NL'(1) << l;
        shadow_m[l]     = d;
        pend_m[l]       = 1'b1;
        dly_m           = d;
      end else begin
        exp_err[cyc + 1] = 1'b1;
      end
    end
    exp_rd = nxt_rd;
    cyc++;
  endtask

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      exp_ld[k]   = '0;
      exp_set[k]  = 1'b0;
      exp_done[k] = 1'b0;
      exp_err[k]  = 1'b0;
    end
    for (int i = 0; i < NL; i++) shadow_m[i] = DI;
    pend_m     = '0;
    dly_m      = 0;
    exp_rd     = DI;
    busy_until = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_apply = 1'b0;
    cmd_lane = '0; cmd_delay = '0; rd_lane = '0;

    repeat (3) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NL; i++) step(0, 0, 0, 0, 0, i);
    step(0, 1, 0, 3, 17, 3);
    step(0, 0, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 3);
    step(0, 1, 0, 0, 9, 0);
    step(0, 1, 0, 1, 10, 1);
    step(0, 1, 0, 2, 11, 2);
    step(0, 1, 1, 0, 0, 0);
    repeat (10) step(0, 1, 0, 4, 5, 1);
    step(0, 1, 0, 12, 22, 4);
    step(0, 0, 0, 0, 0, 4);
    step(0, 1, 0, 6, 13, 6);
    step(0, 1, 1, 0, 0, 6);
    step(0, 0, 0, 0, 0, 6);
    step(1, 0, 0, 0, 0, 6);
    repeat (8) step(0, 0, 0, 0, 0, 6);
    step(0, 1, 0, 5, 31, 5);
    repeat (3) step(0, 0, 0, 0, 0, 5);
    step(0, 0, 0, 0, 0, 4);

    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 31)),
           int'($urandom_range(0, NL - 1)));
    end
    step(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
